operand_issue_unit: RTL

- Upstream/downstream wrapper stage for the combinational decode-and-execute ALU.
- Holds a 4-entry register file and accepts one instruction at a time over a valid/ready handshake.
- Drives registered rs/rt/sel operands into the ALU, captures the ALU result one cycle later and writes it back to the destination register.
- Reports the result and keeps a retired-instruction count.

---
 rtl/operand_issue_unit_pkg.sv | 26 ++
 rtl/operand_issue_unit_reg_file_4x4.sv | 39 +++
 rtl/operand_issue_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/operand_issue_unit_pkg.sv
// Shared encodings and default widths for the operand issue stage and its ALU.
package operand_issue_unit_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 2;
    localparam int CNT_W_DEF  = 8;
    localparam int SEL_W      = 3;

    typedef enum logic [SEL_W-1:0] {
        OP_SUB = 3'd0,
        OP_ADD = 3'd1,
        OP_OR  = 3'd2,
        OP_AND = 3'd3,
        OP_SRL = 3'd4,
        OP_SLL = 3'd5,
        OP_LT  = 3'd6,
        OP_EQ  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/operand_issue_unit_reg_file_4x4.sv
// Register file: two combinational read ports, one write port shared by writeback and load.
module reg_file_4x4
    import operand_issue_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0][DATA_W-1:0] mem;

    // Writeback wins; the issue FSM never lets both strobes fire together anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem <= '0;
        else if (wb_en)
            mem[wb_addr] <= wb_data;
        else if (ld_en)
            mem[ld_addr] <= ld_data;
    end

    assign qa = mem[ra];
    assign qb = mem[rb];

endmodule

// File: rtl/operand_issue_unit.sv
// One-at-a-time issue stage: reads operands, drives the external ALU, writes the result back.
module operand_issue_unit
    import operand_issue_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs,
    input  logic [ADDR_W-1:0] instr_rt,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] ex_rs,
    output logic [DATA_W-1:0] ex_rt,
    output logic [2:0]        ex_sel,
    input  logic [DATA_W-1:0] ex_out,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [ADDR_W-1:0] res_rd,
    output logic              busy,
    output logic [CNT_W-1:0]  retired
);

    state_e            state_q, state_d;
    logic              accept, wb_en, ld_ok;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] rdata_a, rdata_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid) state_d = ISSUE;
            ISSUE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == IDLE);
        busy        = (state_q != IDLE);
        res_valid   = (state_q == DONE);
        wb_en       = (state_q == ISSUE);
        accept      = instr_ready && instr_valid;
        // Acceptance takes priority over a simultaneous external load.
        ld_ok       = ld_en && instr_ready && !instr_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_sel   <= '0;
            rd_q     <= '0;
            res_data <= '0;
            res_rd   <= '0;
            retired  <= '0;
        end else begin
            if (accept) begin
                ex_rs  <= rdata_a;
                ex_rt  <= rdata_b;
                ex_sel <= instr_op;
                rd_q   <= instr_rd;
            end
            if (wb_en) begin
                res_data <= ex_out;
                res_rd   <= rd_q;
                retired  <= retired + CNT_W'(1);
            end
        end
    end

    reg_file_4x4 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra      (instr_rs),
        .rb      (instr_rt),
        .qa      (rdata_a),
        .qb      (rdata_b),
        .wb_en   (wb_en),
        .wb_addr (rd_q),
        .wb_data (ex_out),
        .ld_en   (ld_ok),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

endmodule
